// File: rtl/uart_tx_device.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and a programmable baud divider.
// Defining UART_TX_IRQ_EN adds the CTRL irq_en bit and a registered irq output.
module uart_tx_device #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        ren,
    output logic [31:0] rdata,
    input  logic        wen,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
`ifdef UART_TX_IRQ_EN
    output logic        irq,
`endif
    output logic        txd
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [7:0]      fifo_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     div_q, div_d;
    logic [15:0]     timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;

    logic [1:0]      reg_sel;
    logic            wr_txdata;
    logic            wr_status;
    logic            wr_div;
    logic            full;
    logic            empty;
    logic            busy;
    logic            bit_done;
    logic            pop;
    logic            push_ok;

    logic            unused_bus_bits;

    assign reg_sel   = addr[3:2];
    assign wr_txdata = wen && (reg_sel == 2'd0) && wstrb[0];
    assign wr_status = wen && (reg_sel == 2'd1) && wstrb[0];
    assign wr_div    = wen && (reg_sel == 2'd2);
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign busy      = (state_q != IDLE);
    assign bit_done  = (timer_q == 16'd0);
    assign txd       = txd_q;

    assign unused_bus_bits = ^{addr[31:4], addr[1:0], wdata[31:16], wstrb[3:2]};

`ifdef UART_TX_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;
    logic wr_ctrl;

    assign wr_ctrl = wen && (reg_sel == 2'd3) && wstrb[0];
    assign irq     = irq_q;

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_ctrl) begin
            irq_en_d = wdata[0];
        end
        irq_d = irq_en_q & empty & ~busy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end
`endif

    // The bit timer counts down from the live divider, so a new BAUDDIV
    // is picked up at the next reload, i.e. the next bit boundary.
    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        div_d      = div_q;
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        push_ok    = 1'b0;

        case (state_q)
            IDLE: begin
                pop = !empty;
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    timer_d = div_q;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    timer_d = div_q;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d   = STOP;
                        bit_idx_d = 3'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop) begin
            shift_d   = fifo_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + PW'(1);
            timer_d   = div_q;
            bit_idx_d = 3'd0;
            state_d   = START;
        end

        // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
        push_ok = wr_txdata && (!full || pop);
        if (push_ok) begin
            fifo_d[wr_ptr_q] = wdata[7:0];
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end

        if (wr_txdata && !push_ok) begin
            overflow_d = 1'b1;
        end else if (wr_status && wdata[3]) begin
            overflow_d = 1'b0;
        end

        count_d = count_q + CW'(push_ok) - CW'(pop);

        if (wr_div && wstrb[0]) begin
            div_d[7:0] = wdata[7:0];
        end
        if (wr_div && wstrb[1]) begin
            div_d[15:8] = wdata[15:8];
        end

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= 8'h00;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            div_q      <= DEFAULT_DIV;
            state_q    <= IDLE;
            timer_q    <= 16'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            txd_q      <= 1'b1;
        end else begin
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            div_q      <= div_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
        end
    end

    // Read data is zero whenever this device is not selected so it can be OR-merged.
    always_comb begin
        rdata = 32'h0;
        if (ren) begin
            case (reg_sel)
                2'd1: rdata = {16'h0, 8'(count_q), 4'h0, overflow_q, busy, empty, full};
                2'd2: rdata = {16'h0, div_q};
`ifdef UART_TX_IRQ_EN
                2'd3: rdata = {31'h0, irq_en_q};
`endif
                default: rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_device.sv
// Self-checking bench for uart_tx_device: scoreboard of expected bytes, serial-line monitor.
// Build with UART_TX_IRQ_EN defined to also exercise the irq output.
module tb_uart_tx_device;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        ren;
    logic [31:0] rdata;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        txd;
`ifdef UART_TX_IRQ_EN
    logic        irq;
    bit          irq_en_m;
`endif

    int checks;
    int failures;

    // reference model state
    logic [7:0]  exp_q[$];
    logic [15:0] div_m;
    bit          ovf_m;

    // monitor state
    bit          in_frame;
    bit          start_due;
    bit          last_busy;
    bit          spurious;
    int          frame_idx;
    int          frame_len;
    int          bit_len;
    int          frame_err;
    logic [9:0]  frame_pat;
    logic [9:0]  got_pat;

    uart_tx_device #(
        .FIFO_DEPTH (DEPTH),
        .DEFAULT_DIV(16'd3)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .ren  (ren),
        .rdata(rdata),
        .wen  (wen),
        .wdata(wdata),
        .wstrb(wstrb),
`ifdef UART_TX_IRQ_EN
        .irq  (irq),
`endif
        .txd  (txd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Serial-line monitor: every cycle decides whether a frame must start,
    // then compares each frame against the 10-bit 8N1 pattern of the expected byte.
    always @(posedge clk) begin
        int bit_pos;
        logic [7:0] b;
        #1;
        if (rst) begin
            in_frame  = 1'b0;
            start_due = 1'b0;
            last_busy = 1'b0;
        end else begin
            if (!in_frame) begin
                if (start_due) begin
                    checks++;
                    if (txd !== 1'b0) begin
                        failures++;
                        $display("[TB] FAIL start: txd=%b required 0 for byte %02h", txd, exp_q[0]);
                        void'(exp_q.pop_front());
                    end else begin
                        b         = exp_q.pop_front();
                        frame_pat = {1'b1, b, 1'b0};
                        spurious  = 1'b0;
                        in_frame  = 1'b1;
                    end
                end else begin
                    checks++;
                    if (txd !== 1'b1) begin
                        failures++;
                        $display("[TB] FAIL idle: txd=%b required 1 (unexpected frame)", txd);
                        frame_pat = 10'h0;
                        spurious  = 1'b1;
                        in_frame  = 1'b1;
                    end
                end
                if (in_frame) begin
                    bit_len   = int'(div_m) + 1;
                    frame_len = 10 * bit_len;
                    frame_idx = 0;
                    frame_err = 0;
                    got_pat   = 10'h0;
                end
            end
            last_busy = in_frame;
            if (in_frame) begin
                bit_pos = frame_idx / bit_len;
                if ((frame_idx % bit_len) == (bit_len / 2)) got_pat[bit_pos] = txd;
                if (txd !== frame_pat[bit_pos]) frame_err++;
                frame_idx++;
                if (frame_idx == frame_len) begin
                    in_frame = 1'b0;
                    if (!spurious) begin
                        checks++;
                        if (frame_err != 0) begin
                            failures++;
                            $display("[TB] FAIL frame: bits=%b required %b (%0d cycles wrong)",
                                     got_pat, frame_pat, frame_err);
                        end
                    end
                end
            end
            start_due = !in_frame && (exp_q.size() > 0);
        end
    end

    function automatic logic [31:0] expectedReg(input logic [1:0] idx);
        logic [31:0] v;
        v = 32'h0;
        case (idx)
            2'd1: v = {16'h0, 8'(exp_q.size()), 4'h0, ovf_m, last_busy,
                       exp_q.size() == 0, exp_q.size() == DEPTH};
            2'd2: v = {16'h0, div_m};
`ifdef UART_TX_IRQ_EN
            2'd3: v = {31'h0, irq_en_m};
`endif
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // One bus write; the model is updated at the moment the write is issued.
    task automatic applyStimulus(input logic [1:0] idx, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] r;
        @(negedge clk);
        r     = $urandom;
        addr  = {r[31:4], idx, r[1:0]};
        wdata = data;
        wstrb = strb;
        wen   = 1'b1;
        case (idx)
            2'd0: if (strb[0]) begin
                if (exp_q.size() < DEPTH || (exp_q.size() > 0 && !in_frame)) exp_q.push_back(data[7:0]);
                else ovf_m = 1'b1;
            end
            2'd1: if (strb[0] && data[3]) ovf_m = 1'b0;
            2'd2: begin
                if (strb[0]) div_m[7:0]  = data[7:0];
                if (strb[1]) div_m[15:8] = data[15:8];
            end
`ifdef UART_TX_IRQ_EN
            2'd3: if (strb[0]) irq_en_m = data[0];
`endif
            default: ;
        endcase
        @(posedge clk);
        #1;
        wen = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] idx, input bit use_model,
                               input logic [31:0] exp_const);
        logic [31:0] r;
        logic [31:0] expv;
        @(negedge clk);
        r    = $urandom;
        addr = {r[31:4], idx, r[1:0]};
        ren  = 1'b1;
        expv = use_model ? expectedReg(idx) : exp_const;
        #1;
        checks++;
        if (rdata !== expv) begin
            failures++;
            $display("[TB] FAIL %s: rdata=%08h required %08h", name, rdata, expv);
        end
        ren = 1'b0;
    endtask

    task automatic checkTxd(input string name, input logic expv);
        checks++;
        if (txd !== expv) begin
            failures++;
            $display("[TB] FAIL %s: txd=%b required %b", name, txd, expv);
        end
    endtask

    task automatic waitIdle(input int max_cycles);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame || last_busy) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || in_frame || last_busy) begin
            failures++;
            $display("[TB] FAIL drain: %0d bytes still pending after %0d cycles, required 0",
                     exp_q.size(), max_cycles);
        end
    endtask

`ifdef UART_TX_IRQ_EN
    task automatic checkIrq(input string name, input logic expv);
        checks++;
        if (irq !== expv) begin
            failures++;
            $display("[TB] FAIL %s: irq=%b required %b", name, irq, expv);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        failures++;
        $display("[TB] FAIL timeout: simulation did not finish, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n;
        int sel;
        checks   = 0;
        failures = 0;
        rst   = 1'b1;
        addr  = 32'h0;
        ren   = 1'b0;
        wen   = 1'b0;
        wdata = 32'h0;
        wstrb = 4'h0;
        div_m = 16'd3;
        ovf_m = 1'b0;
`ifdef UART_TX_IRQ_EN
        irq_en_m = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checkTxd("txd in reset", 1'b1);
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("STATUS after reset", 2'd1, 1'b0, 32'h0000_0002);
        checkOutput("BAUDDIV after reset", 2'd2, 1'b0, 32'h0000_0003);
        checkOutput("TXDATA reads zero", 2'd0, 1'b0, 32'h0);
        checkOutput("CTRL after reset", 2'd3, 1'b0, 32'h0);
        checkTxd("txd idle", 1'b1);

        $display("[TB] single byte A5");
        applyStimulus(2'd0, 32'h0000_00A5, 4'h1);
        checkOutput("STATUS queued", 2'd1, 1'b0, 32'h0000_0100);
        checkOutput("STATUS sending", 2'd1, 1'b0, 32'h0000_0006);
        repeat (20) @(negedge clk);
        checkOutput("STATUS mid frame", 2'd1, 1'b1, 32'h0);
        waitIdle(200);
        checkOutput("STATUS after frame", 2'd1, 1'b0, 32'h0000_0002);

        $display("[TB] fill FIFO and overflow");
        for (int i = 0; i < 9; i++) applyStimulus(2'd0, 32'($urandom_range(0, 255)), 4'h1);
        applyStimulus(2'd0, 32'h0000_0077, 4'h1);
        checkOutput("STATUS overflow", 2'd1, 1'b0, 32'h0000_080D);
        applyStimulus(2'd1, 32'h0000_0008, 4'h1);
        checkOutput("STATUS overflow cleared", 2'd1, 1'b0, 32'h0000_0805);
        waitIdle(1000);
        checkOutput("STATUS drained", 2'd1, 1'b0, 32'h0000_0002);

        $display("[TB] BAUDDIV zero");
        applyStimulus(2'd2, 32'h0, 4'b0001);
        checkOutput("BAUDDIV zero", 2'd2, 1'b0, 32'h0);
        applyStimulus(2'd0, 32'h0000_0001, 4'h1);
        waitIdle(100);
        applyStimulus(2'd2, 32'h0000_5A00, 4'b0010);
        checkOutput("BAUDDIV high lane", 2'd2, 1'b0, 32'h0000_5A00);
        applyStimulus(2'd2, 32'hFFFF_0003, 4'b0001);
        checkOutput("BAUDDIV low lane", 2'd2, 1'b0, 32'h0000_5A03);

        $display("[TB] randomized traffic");
        for (int round = 0; round < 5; round++) begin
            waitIdle(5000);
            applyStimulus(2'd2, 32'($urandom_range(0, 3)), 4'b0011);
            checkOutput("BAUDDIV random", 2'd2, 1'b1, 32'h0);
            for (int k = 0; k < 30; k++) begin
                sel = $urandom_range(0, 9);
                if (sel < 5) applyStimulus(2'd0, $urandom, (sel == 0) ? 4'b1110 : 4'b0001);
                else if (sel < 8) checkOutput("STATUS random", 2'd1, 1'b1, 32'h0);
                else if (sel == 8) repeat ($urandom_range(1, 30)) @(negedge clk);
                else applyStimulus(2'd1, 32'h0000_0008, 4'h1);
            end
        end
        waitIdle(5000);

        $display("[TB] reset mid frame");
        applyStimulus(2'd2, 32'h0000_0003, 4'b0011);
        for (int i = 0; i < 3; i++) applyStimulus(2'd0, 32'($urandom_range(0, 255)), 4'h1);
        n = 0;
        while (!(in_frame && frame_idx >= 12) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(in_frame && frame_idx >= 12)) begin
            failures++;
            $display("[TB] FAIL reach DATA: frame not in data bits after %0d cycles, required in frame", n);
        end
        rst = 1'b1;
        #1;
        checkTxd("txd on async reset", 1'b1);
        exp_q.delete();
        in_frame  = 1'b0;
        start_due = 1'b0;
        last_busy = 1'b0;
        ovf_m     = 1'b0;
        div_m     = 16'd3;
`ifdef UART_TX_IRQ_EN
        irq_en_m  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("STATUS after mid reset", 2'd1, 1'b0, 32'h0000_0002);
        repeat (100) @(negedge clk);
        checkOutput("STATUS still idle", 2'd1, 1'b0, 32'h0000_0002);

`ifdef UART_TX_IRQ_EN
        $display("[TB] interrupt");
        applyStimulus(2'd3, 32'h0000_0001, 4'h1);
        checkOutput("CTRL irq_en", 2'd3, 1'b0, 32'h0000_0001);
        @(negedge clk);
        checkIrq("irq idle empty", 1'b1);
        applyStimulus(2'd0, 32'h0000_003C, 4'h1);
        @(negedge clk);
        @(negedge clk);
        checkIrq("irq after write", 1'b0);
        n = 0;
        while (in_frame && n < 100) begin
            if (n % 8 == 0) checkIrq("irq during frame", 1'b0);
            @(negedge clk);
            n++;
        end
        checkIrq("irq last stop cycle", 1'b0);
        @(negedge clk);
        checkIrq("irq frame end", 1'b0);
        @(negedge clk);
        checkIrq("irq one cycle after frame", 1'b1);
        applyStimulus(2'd3, 32'h0, 4'h1);
        @(negedge clk);
        @(negedge clk);
        checkIrq("irq disabled", 1'b0);
        waitIdle(200);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
